pwm_deadtime: RTL and testbench
===============================

Name: pwm_deadtime

Overview:
- Downstream stage of the PWM generator. Consumes its single-ended `wave` output and produces a complementary high-side/low-side gate pair (`out_h`, `out_l`).
- Inserts a programmable dead time on every transition, so both outputs are never high together.
- Includes a latching break (fault) input that forces both outputs low until software clears it.

Parameters:
- DT_W, 8, width of the dead-time count `dtg` (max dead time 2^DT_W-1 clocks).

Ports:
- clk  input  1  system clock, same domain as the PWM generator.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  output enable; 0 forces both outputs low and the FSM to IDLE.
- wave_in  input  1  PWM waveform; registered in the clk domain upstream, so no synchronizer.
- dtg  input  DT_W  dead time in clk cycles; sampled when a dead-time interval starts.
- brk  input  1  break/fault request, sampled on clk, level-sensitive.
- fault_clr  input  1  one-cycle pulse that clears the latched fault.
- out_h  output  1  high-side drive, registered.
- out_l  output  1  low-side drive, registered.
- fault  output  1  latched break status, registered.

Behaviour:
- Reset (async, rst=1): out_h=0, out_l=0, fault=0, state=IDLE, cnt=0.
- States: IDLE, DT_TO_H, HIGH, DT_TO_L, LOW, BREAK.
- Output mapping per state:
  - IDLE, DT_TO_H, DT_TO_L, BREAK: both outputs 0.
  - HIGH: out_h=1, out_l=0.
  - LOW: out_h=0, out_l=1.
  - All outputs are registered from the next state.
- Priority: BREAK entry > en=0 > normal transitions.
- BREAK:
  - brk=1 in any state → next edge: state=BREAK, fault=1, both outputs 0.
  - Leave BREAK only when fault_clr=1 and brk=0 in the same cycle → IDLE, fault=0.
  - fault_clr with brk still 1 is ignored.
- en=0, no brk: next state is IDLE, any count is abandoned.
- IDLE with en=1:
  - wave_in=1 → DT_TO_H.
  - wave_in=0 → DT_TO_L.
  - Dead time is applied on start-up as well.
- LOW with wave_in=1:
  - dtg=0 → directly to HIGH (out_l falls and out_h rises on the same edge).
  - dtg≥1 → DT_TO_H, loading cnt=dtg-1.
- HIGH with wave_in=0: symmetric, going to LOW or DT_TO_L.
- DT_TO_H:
  - cnt!=0 → decrement.
  - cnt==0 and wave_in=1 → HIGH.
  - wave_in=0 at any point → LOW immediately. A pulse no longer than the dead time is swallowed; out_h never rises.
  - Timing: with wave_in rising in the cycle before edge k, out_l=0 from edge k and out_h=1 from edge k+N (N=dtg). Both are low for exactly N cycles.
- DT_TO_L: mirror of DT_TO_H.
- Width rules:
  - High-side pulse width = wave_in high width − dtg when wave_in high width > dtg, else 0.
  - Low-side width likewise.
- Changing dtg mid-interval does not affect the interval in progress.
- cnt is DT_W bits and never wraps: it is only decremented when nonzero.
- Invariant: out_h & out_l == 0 in every cycle, including reset release and break.

Decomposition:
- Shared package (pwm_pkg) holds:
  - `dt_state_t` enum (IDLE, DT_TO_H, HIGH, DT_TO_L, LOW, BREAK).
  - Default DT_W.
- No sub-module needed. Single FSM plus a counter in one module.
- Top-level integration instantiates PWM → pwm_deadtime.

Test Plan:
- Basic square wave: en=1, dtg=5, wave_in high 100 / low 900 cycles → out_h high 95 cycles, out_l high 895 cycles, both low exactly 5 cycles at each edge.
- Zero dead time: dtg=0, same wave_in → out_h==wave_in and out_l==~wave_in, delayed 1 cycle; no cycle with both low after steady state.
- Short pulse: dtg=10, wave_in high for 6 cycles → out_h stays 0, out_l drops for 6 cycles then returns to 1; no overlap.
- Break: brk asserted during HIGH → next edge out_h=0, out_l=0, fault=1. fault_clr while brk=1 → no change. brk=0 then fault_clr → IDLE, then dead time of dtg cycles before the first output rises.
- Reset/enable mid-operation: assert rst during DT_TO_H → outputs and fault 0 immediately (async). Drop en during LOW → both outputs 0 next edge. Re-enable with wave_in=0 → out_l rises after dtg cycles.
- Continuous checker across all scenarios: assertion `!(out_h && out_l)` every cycle. A dtg change mid-interval (5→20) takes effect only on the following transition.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the PWM output stage: dead-time FSM states and default widths.
package pwm_pkg;

    localparam int DT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        DT_TO_H,
        HIGH,
        DT_TO_L,
        LOW,
        BREAK
    } dt_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time and a latching break input.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wave_in,
    input  logic [DT_W-1:0] dtg,
    input  logic            brk,
    input  logic            fault_clr,
    output logic            out_h,
    output logic            out_l,
    output logic            fault
);

    dt_state_t       state, state_nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;
    logic [DT_W-1:0] dt_load;

    // The entry cycle of a dead-time interval counts as the first cycle, so load N-1.
    assign dt_load = (dtg == '0) ? '0 : dtg - DT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (brk) begin
            state_nxt = BREAK;
            cnt_nxt   = '0;
        end else if (state == BREAK) begin
            if (fault_clr) state_nxt = IDLE;
        end else if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = wave_in ? DT_TO_H : DT_TO_L;
                    cnt_nxt   = dt_load;
                end
                HIGH: begin
                    if (!wave_in) begin
                        state_nxt = (dtg == '0) ? LOW : DT_TO_L;
                        cnt_nxt   = dt_load;
                    end
                end
                LOW: begin
                    if (wave_in) begin
                        state_nxt = (dtg == '0) ? HIGH : DT_TO_H;
                        cnt_nxt   = dt_load;
                    end
                end
                DT_TO_H: begin
                    // A reversal inside the interval swallows the pulse entirely.
                    if (!wave_in) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt != '0) begin
                        cnt_nxt   = cnt - DT_W'(1);
                    end else begin
                        state_nxt = HIGH;
                    end
                end
                DT_TO_L: begin
                    if (wave_in) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt != '0) begin
                        cnt_nxt   = cnt - DT_W'(1);
                    end else begin
                        state_nxt = LOW;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out_h <= 1'b0;
            out_l <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out_h <= (state_nxt == HIGH);
            out_l <= (state_nxt == LOW);
            fault <= (state_nxt == BREAK);
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: pulse widths, dead time, break latch, reset and enable.
module tb_pwm_deadtime;

    localparam int DT_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            wave_in = 1'b0;
    logic [DT_W-1:0] dtg = '0;
    logic            brk = 1'b0;
    logic            fault_clr = 1'b0;
    logic            out_h, out_l, fault;

    int n_run  = 0;
    int n_fail = 0;
    int overlap = 0;
    int nh, nl, nb;

    pwm_deadtime #(.DT_W(DT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wave_in   (wave_in),
        .dtg       (dtg),
        .brk       (brk),
        .fault_clr (fault_clr),
        .out_h     (out_h),
        .out_l     (out_l),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert (!(out_h && out_l)) else overlap++;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Hold wave_in for n cycles, tallying out_h-high, out_l-high and both-low samples.
    task automatic run(input logic w, input int n);
        nh = 0; nl = 0; nb = 0;
        wave_in = w;
        repeat (n) begin
            @(negedge clk);
            if (out_h) nh++;
            if (out_l) nl++;
            if (!out_h && !out_l) nb++;
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_out_h", int'(out_h), 0);
        check("rst_out_l", int'(out_l), 0);
        check("rst_fault", int'(fault), 0);
        @(negedge clk);
        rst = 1'b0;

        // settle into LOW with dead time 5
        en = 1'b1; dtg = 8'd5;
        run(0, 5);
        check("start_dead", nb, 5);
        run(0, 1);
        check("start_low", int'(out_l), 1);
        run(0, 40);

        // square wave 100/900, dtg=5
        run(1, 100);
        check("sq_h", nh, 95);
        check("sq_bl_rise", nb, 5);
        run(0, 900);
        check("sq_l", nl, 895);
        check("sq_bl_fall", nb, 5);

        // zero dead time tracks wave_in one cycle late
        dtg = 8'd0;
        run(1, 100);
        check("dt0_h", nh, 100);
        check("dt0_bl_rise", nb, 0);
        run(0, 900);
        check("dt0_l", nl, 900);
        check("dt0_bl_fall", nb, 0);

        // pulse shorter than dead time is swallowed
        dtg = 8'd10;
        run(1, 6);
        check("short_h", nh, 0);
        check("short_bl", nb, 6);
        run(0, 20);
        check("short_l", nl, 20);

        // dtg change mid-interval applies only to the next transition
        dtg = 8'd5;
        run(1, 2);
        check("dtchg_bl0", nb, 2);
        dtg = 8'd20;
        run(1, 98);
        check("dtchg_h", nh, 95);
        run(0, 100);
        check("dtchg_next_l", nl, 80);
        check("dtchg_next_bl", nb, 20);

        // break during HIGH
        dtg = 8'd5;
        run(1, 20);
        check("pre_brk_h", int'(out_h), 1);
        brk = 1'b1;
        run(1, 1);
        check("brk_h", int'(out_h), 0);
        check("brk_l", int'(out_l), 0);
        check("brk_fault", int'(fault), 1);
        fault_clr = 1'b1;
        run(1, 1);
        check("clr_ign_fault", int'(fault), 1);
        fault_clr = 1'b0; brk = 1'b0;
        run(1, 3);
        check("latched_fault", int'(fault), 1);
        check("latched_h", nh, 0);
        fault_clr = 1'b1;
        run(1, 1);
        check("clr_fault", int'(fault), 0);
        check("clr_h", int'(out_h), 0);
        fault_clr = 1'b0;
        run(1, 5);
        check("post_clr_bl", nb, 5);
        run(1, 1);
        check("post_clr_h", int'(out_h), 1);

        // async reset while HIGH, then during DT_TO_H
        rst = 1'b1;
        #1;
        check("arst_h", int'(out_h), 0);
        check("arst_fault", int'(fault), 0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 30);
        check("after_rst_low", int'(out_l), 1);
        run(1, 2);
        rst = 1'b1;
        #1;
        check("arst_dt_l", int'(out_l), 0);
        check("arst_dt_h", int'(out_h), 0);
        @(negedge clk);
        rst = 1'b0;
        run(1, 5);
        check("rst_restart_bl", nb, 5);
        run(1, 1);
        check("rst_restart_h", int'(out_h), 1);

        // enable drop in LOW, then re-enable
        run(0, 20);
        check("pre_en_low", int'(out_l), 1);
        en = 1'b0;
        run(0, 1);
        check("en0_l", int'(out_l), 0);
        run(0, 3);
        check("en0_hold", nb, 3);
        en = 1'b1;
        run(0, 5);
        check("reen_bl", nb, 5);
        run(0, 1);
        check("reen_l", int'(out_l), 1);

        check("overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
